// File: rtl/alu_exec_unit.sv
// Registered execute stage: ALU control decode, 32-bit ALU,
// zero/overflow flags, PC+4 and branch target, all captured per edge.
module alu_exec_unit #(
   parameter int WIDTH  = 32,
   parameter int PC_INC = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             aluop1,
   input  logic             aluop0,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] sext_imm,
   output logic             out_valid,
   output logic [2:0]       gout,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] br_target
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SLL = 3'b011;
   localparam logic [2:0] OP_NOR = 3'b100;
   localparam logic [2:0] OP_SRL = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   logic [2:0]       ctl;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] alu_y;
   logic             ovf;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] br_y;
   logic [4:0]       shamt;

   always_comb begin
      ctl = OP_ADD;
      unique case ({aluop1, aluop0})
         2'b00: ctl = OP_ADD;
         2'b01: ctl = OP_SUB;
         2'b11: ctl = OP_OR;
         2'b10: begin
            case (funct)
               6'b100000: ctl = OP_ADD;
               6'b100010: ctl = OP_SUB;
               6'b100100: ctl = OP_AND;
               6'b100101: ctl = OP_OR;
               6'b100111: ctl = OP_NOR;
               6'b101010: ctl = OP_SLT;
               6'b000000: ctl = OP_SLL;
               6'b000010: ctl = OP_SRL;
               default:   ctl = OP_ADD;
            endcase
         end
         default: ctl = OP_ADD;
      endcase
   end

   assign sum   = src_a + src_b;
   assign diff  = src_a - src_b;
   assign shamt = src_b[4:0];

   always_comb begin
      alu_y = '0;
      ovf   = 1'b0;
      unique case (ctl)
         OP_AND: alu_y = src_a & src_b;
         OP_OR:  alu_y = src_a | src_b;
         OP_NOR: alu_y = ~(src_a | src_b);
         OP_ADD: begin
            alu_y = sum;
            ovf   = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                    (sum[WIDTH-1] != src_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_y = diff;
            ovf   = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                    (diff[WIDTH-1] != src_a[WIDTH-1]);
         end
         // full signed compare, independent of subtract overflow
         OP_SLT: alu_y = {{(WIDTH-1){1'b0}},
                          ($signed(src_a) < $signed(src_b))};
         OP_SLL: alu_y = src_a << shamt;
         OP_SRL: alu_y = src_a >> shamt;
         default: alu_y = sum;
      endcase
   end

   assign pc_inc = pc + WIDTH'(PC_INC);
   assign br_y   = pc_inc + (sext_imm << 2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         gout      <= 3'b000;
         result    <= '0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         pc_plus4  <= '0;
         br_target <= '0;
      end else begin
         out_valid <= in_valid;
         gout      <= ctl;
         result    <= alu_y;
         zero      <= (alu_y == '0);
         overflow  <= ovf;
         pc_plus4  <= pc_inc;
         br_target <= br_y;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed
// expected values.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        aluop1 = 1'b0;
   logic        aluop0 = 1'b0;
   logic [5:0]  funct = '0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic [31:0] pc = '0;
   logic [31:0] sext_imm = '0;
   logic        out_valid;
   logic [2:0]  gout;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic [31:0] pc_plus4;
   logic [31:0] br_target;

   int n_cmp = 0;
   int n_bad = 0;

   alu_exec_unit dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .aluop1(aluop1),
      .aluop0(aluop0),
      .funct(funct),
      .src_a(src_a),
      .src_b(src_b),
      .pc(pc),
      .sext_imm(sext_imm),
      .out_valid(out_valid),
      .gout(gout),
      .result(result),
      .zero(zero),
      .overflow(overflow),
      .pc_plus4(pc_plus4),
      .br_target(br_target)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // drive one vector, let one edge capture it, sample 1ns later
   task automatic run(input logic [1:0]  op,
                      input logic [5:0]  fn,
                      input logic [31:0] a,
                      input logic [31:0] b);
      in_valid = 1'b1;
      {aluop1, aluop0} = op;
      funct = fn;
      src_a = a;
      src_b = b;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_alu(input string tag,
                          input logic [31:0] r,
                          input logic z,
                          input logic [2:0] g,
                          input logic ov);
      chk({tag, ".result"}, result, r);
      chk({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
      chk({tag, ".gout"}, {29'd0, gout}, {29'd0, g});
      chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, ov});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, ".gout"}, {29'd0, gout}, 32'd0);
      chk({tag, ".result"}, result, 32'd0);
      chk({tag, ".zero"}, {31'd0, zero}, 32'd0);
      chk({tag, ".ovf"}, {31'd0, overflow}, 32'd0);
      chk({tag, ".pc4"}, pc_plus4, 32'd0);
      chk({tag, ".br"}, br_target, 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("rst_hold");
      #2 reset = 1'b0;

      run(2'b10, 6'b100000, 32'd7, 32'd5);
      chk("add.valid", {31'd0, out_valid}, 32'd1);
      chk_alu("add", 32'd12, 1'b0, 3'b010, 1'b0);

      run(2'b01, 6'b111111, 32'h1234, 32'h1234);
      chk_alu("beq", 32'd0, 1'b1, 3'b110, 1'b0);

      run(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1);
      chk_alu("slt", 32'd1, 1'b0, 3'b111, 1'b0);
      run(2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF);
      chk_alu("slt_sw", 32'd0, 1'b1, 3'b111, 1'b0);
      run(2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF);
      chk_alu("slt_ext", 32'd1, 1'b0, 3'b111, 1'b0);

      run(2'b10, 6'b000000, 32'd1, 32'd31);
      chk_alu("sll", 32'h80000000, 1'b0, 3'b011, 1'b0);
      run(2'b10, 6'b000010, 32'h80000000, 32'h24);
      chk_alu("srl", 32'h08000000, 1'b0, 3'b101, 1'b0);

      run(2'b10, 6'b100000, 32'h7FFFFFFF, 32'd1);
      chk_alu("add_ov", 32'h80000000, 1'b0, 3'b010, 1'b1);
      run(2'b10, 6'b100010, 32'h80000000, 32'd1);
      chk_alu("sub_ov", 32'h7FFFFFFF, 1'b0, 3'b110, 1'b1);
      run(2'b00, 6'b000000, 32'hFFFFFFFF, 32'd1);
      chk_alu("lw_add", 32'd0, 1'b1, 3'b010, 1'b0);

      run(2'b10, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00);
      chk_alu("and", 32'hF000_F000, 1'b0, 3'b000, 1'b0);
      run(2'b10, 6'b100101, 32'h0000_00F0, 32'h0000_000F);
      chk_alu("or", 32'h0000_00FF, 1'b0, 3'b001, 1'b0);
      run(2'b10, 6'b100111, 32'h0F0F_0000, 32'hF0F0_0000);
      chk_alu("nor", 32'h0000_FFFF, 1'b0, 3'b100, 1'b0);
      run(2'b11, 6'b100010, 32'h0001_0000, 32'h0000_0003);
      chk_alu("ori", 32'h0001_0003, 1'b0, 3'b001, 1'b0);
      run(2'b10, 6'b111111, 32'd3, 32'd4);
      chk_alu("dflt", 32'd7, 1'b0, 3'b010, 1'b0);

      pc = 32'h10;
      sext_imm = 32'hFFFFFFFE;
      run(2'b00, 6'b0, 32'd0, 32'd0);
      chk("pc4", pc_plus4, 32'h14);
      chk("br", br_target, 32'hC);
      pc = 32'hFFFFFFFC;
      sext_imm = 32'd1;
      run(2'b00, 6'b0, 32'd0, 32'd0);
      chk("pc4_wrap", pc_plus4, 32'h0);
      chk("br_wrap", br_target, 32'h4);

      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("nvalid", {31'd0, out_valid}, 32'd0);

      pc = 32'h100;
      sext_imm = 32'd4;
      run(2'b10, 6'b100000, 32'd9, 32'd9);
      chk_alu("pre_rst", 32'd18, 1'b0, 3'b010, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk_all_zero("rst_async");
      #2 reset = 1'b0;
      run(2'b10, 6'b100010, 32'd10, 32'd3);
      chk("post.valid", {31'd0, out_valid}, 32'd1);
      chk_alu("post", 32'd7, 1'b0, 3'b110, 1'b0);
      chk("post.pc4", pc_plus4, 32'h104);
      chk("post.br", br_target, 32'h114);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
